// File: rtl/fifo_width_conv.sv
// Single-clock FIFO: WR_W-bit words in, RD_W-bit slices out in MSB_FIRST order. Read data and all flags/counts are registered, one cycle after the edge.
// No backpressure: a write while full is dropped with an overflow pulse; a read while empty gives an underflow pulse and valid stays low.
module fifo_width_conv #(
    parameter int WR_W      = 8,
    parameter int RD_W      = 1,
    parameter int DEPTH     = 32,
    parameter int MSB_FIRST = 1,
    parameter int AF_LVL    = DEPTH - 2,
    parameter int AE_LVL    = WR_W / RD_W
) (
    input  logic                                           clk_i,
    input  logic                                           rst_n_i,
    input  logic                                           flush_i,
    input  logic [WR_W-1:0]                                din_i,
    input  logic                                           wr_en_i,
    input  logic                                           rd_en_i,
    output logic [RD_W-1:0]                                dout_o,
    output logic                                           valid_o,
    output logic                                           full_o,
    output logic                                           empty_o,
    output logic                                           almost_full_o,
    output logic                                           almost_empty_o,
    output logic                                           overflow_o,
    output logic                                           underflow_o,
    output logic [$clog2(DEPTH*(WR_W/RD_W)+1)-1:0]         rd_data_count_o,
    output logic [$clog2(DEPTH+1)-1:0]                     wr_data_count_o
);

    localparam int R   = WR_W / RD_W;
    localparam int AW  = $clog2(DEPTH);
    localparam int SW  = (R > 1) ? $clog2(R) : 1;
    localparam int RCW = $clog2(DEPTH * R + 1);
    localparam int WCW = $clog2(DEPTH + 1);

    localparam logic [SW-1:0]  SL_LAST = SW'(R - 1);
    localparam logic [RCW-1:0] R_C     = RCW'(R);
    localparam logic [RCW-1:0] AE_C    = RCW'(AE_LVL);
    localparam logic [WCW-1:0] AF_C    = WCW'(AF_LVL);
    localparam logic [WCW-1:0] DEPTH_C = WCW'(DEPTH);

    logic [WR_W-1:0] mem [DEPTH];

    logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]   rd_word_q, rd_word_d;
    logic [SW-1:0]   rd_sl_q,   rd_sl_d;
    logic [RCW-1:0]  occ_q,     occ_d;
    logic [WCW-1:0]  wcnt_q,    wcnt_d;
    logic [RD_W-1:0] dout_q,    dout_d;
    logic            valid_q,   valid_d;
    logic            full_q,    full_d;
    logic            empty_q,   empty_d;
    logic            af_q,      af_d;
    logic            ae_q,      ae_d;
    logic            ovf_q,     ovf_d;
    logic            unf_q,     unf_d;

    logic            wr_acc;
    logic            rd_acc;
    logic            rd_last;
    logic [WR_W-1:0] word_sh;
    int unsigned     shamt;

    // Acceptance uses the registered full/empty, so a same-cycle read never frees room for a write.
    assign wr_acc  = wr_en_i && !full_q  && !flush_i;
    assign rd_acc  = rd_en_i && !empty_q && !flush_i;
    assign rd_last = (rd_sl_q == SL_LAST);

    always_comb begin
        shamt = 0;
        if (MSB_FIRST != 0) begin
            shamt = (R - 1 - int'(rd_sl_q)) * RD_W;
        end else begin
            shamt = int'(rd_sl_q) * RD_W;
        end
        word_sh = mem[rd_word_q] >> shamt;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_word_d = rd_word_q;
        rd_sl_d   = rd_sl_q;
        occ_d     = occ_q;
        wcnt_d    = wcnt_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_word_d = '0;
            rd_sl_d   = '0;
            occ_d     = '0;
            wcnt_d    = '0;
        end else begin
            ovf_d = wr_en_i && full_q;
            unf_d = rd_en_i && empty_q;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                occ_d    = occ_d + R_C;
                wcnt_d   = wcnt_d + WCW'(1);
            end
            if (rd_acc) begin
                dout_d  = word_sh[RD_W-1:0];
                valid_d = 1'b1;
                occ_d   = occ_d - RCW'(1);
                if (rd_last) begin
                    rd_sl_d   = '0;
                    rd_word_d = rd_word_q + AW'(1);
                    wcnt_d    = wcnt_d - WCW'(1);
                end else begin
                    rd_sl_d = rd_sl_q + SW'(1);
                end
            end
        end

        full_d  = (wcnt_d == DEPTH_C);
        empty_d = (occ_d == '0);
        af_d    = (wcnt_d >= AF_C);
        ae_d    = (occ_d <= AE_C);
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_word_q <= '0;
            rd_sl_q   <= '0;
            occ_q     <= '0;
            wcnt_q    <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_word_q <= rd_word_d;
            rd_sl_q   <= rd_sl_d;
            occ_q     <= occ_d;
            wcnt_q    <= wcnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign dout_o          = dout_q;
    assign valid_o         = valid_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;
    assign almost_full_o   = af_q;
    assign almost_empty_o  = ae_q;
    assign overflow_o      = ovf_q;
    assign underflow_o     = unf_q;
    assign rd_data_count_o = occ_q;
    assign wr_data_count_o = wcnt_q;

endmodule

// File: doc/fifo_width_conv.md
FIFO_WIDTH_CONV -- requirements
Module: fifo_width_conv

Interface
REQ-001 SHALL have parameter WR_W, default 8, write word width in bits.
REQ-002 SHALL have parameter RD_W, default 1, read word width in bits; WR_W SHALL be an integer multiple of RD_W, with ratio R = WR_W/RD_W.
REQ-003 SHALL have parameter DEPTH, default 32, storage capacity in write words; power of two, at least 2.
REQ-004 SHALL have parameter MSB_FIRST, default 1; 1 = the most significant RD_W slice of each write word is read first, 0 = least significant first.
REQ-005 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold in write words.
REQ-006 SHALL have parameter AE_LVL, default R, almost_empty threshold in read words.
REQ-007 clk  in  1  single clock for both the write side and the read side.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 flush  in  1  synchronous clear of all contents.
REQ-010 din  in  WR_W  write data.
REQ-011 wr_en  in  1  write request.
REQ-012 rd_en  in  1  read request.
REQ-013 dout  out  RD_W  read data.
REQ-014 valid  out  1  dout updated this cycle.
REQ-015 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-016 overflow, underflow  out  1 each  single-cycle error pulses.
REQ-017 rd_data_count  out  clog2(DEPTH*R+1)  occupancy O, in read words.
REQ-018 wr_data_count  out  clog2(DEPTH+1)  ceil(O/R), in write words.

Function
REQ-019 Occupancy O SHALL range from 0 to DEPTH*R.
- Accepted write: O increases by R.
- Accepted read: O decreases by 1.
- Accepted write and accepted read in the same cycle: O increases by R-1.
REQ-020 full SHALL equal (wr_data_count == DEPTH); a write is accepted only when wr_en=1 and full=0, with full evaluated before any same-cycle read.
REQ-021 A read SHALL be accepted only when rd_en=1 and empty=0; empty SHALL equal (O == 0).
REQ-022 Read latency SHALL be 1 cycle: an accepted read at edge N drives the next slice on dout and valid=1 after edge N+1; valid=0 in all other cycles.
REQ-023 dout SHALL hold its last value when no read is accepted.
REQ-024 Slice order within a write word SHALL follow MSB_FIRST; write words SHALL be read in write order.
REQ-025 Write and read pointers SHALL wrap modulo DEPTH (write words) and modulo DEPTH*R (read words) without gaps.
REQ-026 A write is allowed into a slot as soon as its last slice has been read in a previous cycle; a slot that is partially read SHALL count as occupied.
REQ-027 almost_full SHALL equal (wr_data_count >= AF_LVL).
REQ-028 almost_empty SHALL equal (rd_data_count <= AE_LVL).
REQ-029 overflow SHALL pulse for 1 cycle when wr_en=1 and full=1; the data is dropped and state is unchanged.
REQ-030 underflow SHALL pulse for 1 cycle when rd_en=1 and empty=0 is false (i.e. empty=1); dout holds and valid=0.
REQ-031 flush=1 SHALL take priority over wr_en and rd_en in the same cycle. At the next edge it SHALL:
- zero both pointers and O;
- drive valid=0;
- leave dout unchanged;
- suppress overflow and underflow.
REQ-032 All flags and counts SHALL be registered outputs consistent with O after each edge.

Reset
REQ-033 rst=0 SHALL immediately force:
- pointers, O, rd_data_count, wr_data_count = 0;
- empty=1, almost_empty=1;
- full, almost_full, valid, overflow, underflow = 0;
- dout = 0.
REQ-034 Reset SHALL be honoured mid-operation; no write or read SHALL be accepted while rst=0.
REQ-035 Operation SHALL resume on the first rising edge of clk after rst returns to 1.

Verification
REQ-036 Default parameters, write 0x40 then 8 reads -> dout sequence 0,1,0,0,0,0,0,0 with valid=1 each cycle; rd_data_count 8->0; empty=1 after the 8th read.
REQ-037 Write 30 bytes back-to-back -> rd_data_count=240, wr_data_count=30, almost_full=1, full=0. Then 2 more bytes -> full=1. A 33rd write -> overflow=1 for 1 cycle and counts unchanged.
REQ-038 Full FIFO, wr_en=1 and rd_en=1 in the same cycle -> read accepted, write rejected with overflow=1, rd_data_count=255. The next write is still rejected until 8 reads have completed.
REQ-039 MSB_FIRST=0, WR_W=8, RD_W=2, write 0xB4 -> dout sequence 0,1,3,2.
REQ-040 Empty FIFO, rd_en=1 -> underflow=1, valid=0, dout unchanged.
REQ-041 rst=0 asserted mid-write burst, and separately flush=1 with wr_en=1 -> counts=0 and empty=1 on the following cycle; the flushed write is not stored.
